// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: sends device ID, register address and register data
// for one {reg_addr, reg_data} word per start/busy handshake.
module sccb_write_master #(
   parameter int         CLK_FREQ = 25_000_000,
   parameter int         SCL_FREQ = 100_000,
   parameter logic [7:0] DEV_ADDR = 8'h42
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] cfg_data,
   output logic        busy,
   output logic        ack_err,
   output logic        sccb_scl,
   output logic        sccb_sda_o,
   output logic        sccb_sda_oe,
   input  logic        sccb_sda_i
);

   localparam int            QDIV  = CLK_FREQ / (4 * SCL_FREQ);
   localparam int            QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_STOP,
      S_GAP
   } state_t;

   state_t        r_state;
   logic [QW-1:0] r_qcnt;
   logic [1:0]    r_quarter;
   logic [3:0]    r_bitIdx;
   logic [1:0]    r_phase;
   logic [15:0]   r_data;
   logic          r_errSticky;

   state_t        w_nextState;
   logic [QW-1:0] w_nextQcnt;
   logic [1:0]    w_nextQuarter;
   logic [3:0]    w_nextBitIdx;
   logic [1:0]    w_nextPhase;
   logic [15:0]   w_nextData;
   logic          w_qEnd;
   logic          w_stepEnd;
   logic          w_sampleAck;
   logic [7:0]    w_byte;
   logic          w_dataBit;
   logic          w_sclNext;
   logic          w_sdaNext;
   logic          w_oeNext;

   assign w_qEnd      = (r_qcnt == QLAST);
   assign w_stepEnd   = w_qEnd && (r_quarter == 2'd3);
   assign w_sampleAck = (r_state == S_BIT) && (r_bitIdx == 4'd8) &&
                        (r_quarter == 2'd2) && (r_qcnt == '0);

   // Sequencing: quarter counter, 4 quarters per step, 9 bits per phase, 3 phases.
   always_comb begin
      w_nextState   = r_state;
      w_nextQcnt    = r_qcnt;
      w_nextQuarter = r_quarter;
      w_nextBitIdx  = r_bitIdx;
      w_nextPhase   = r_phase;
      w_nextData    = r_data;
      if (r_state == S_IDLE) begin
         if (start) begin
            w_nextState   = S_START;
            w_nextData    = cfg_data;
            w_nextQcnt    = '0;
            w_nextQuarter = 2'd0;
            w_nextBitIdx  = 4'd0;
            w_nextPhase   = 2'd0;
         end
      end else begin
         w_nextQcnt = w_qEnd ? '0 : r_qcnt + 1'b1;
         if (w_qEnd) begin
            w_nextQuarter = r_quarter + 2'd1;
         end
         if (w_stepEnd) begin
            unique case (r_state)
               S_START: begin
                  w_nextState  = S_BIT;
                  w_nextBitIdx = 4'd0;
                  w_nextPhase  = 2'd0;
               end
               S_BIT: begin
                  if (r_bitIdx == 4'd8) begin
                     w_nextBitIdx = 4'd0;
                     if (r_phase == 2'd2) begin
                        w_nextState = S_STOP;
                     end else begin
                        w_nextPhase = r_phase + 2'd1;
                     end
                  end else begin
                     w_nextBitIdx = r_bitIdx + 4'd1;
                  end
               end
               S_STOP:  w_nextState = S_GAP;
               S_GAP:   w_nextState = S_IDLE;
               default: w_nextState = S_IDLE;
            endcase
         end
      end
   end

   // Pin values are derived from the upcoming step so they register in lockstep with it.
   always_comb begin
      unique case (w_nextPhase)
         2'd0:    w_byte = DEV_ADDR;
         2'd1:    w_byte = w_nextData[15:8];
         default: w_byte = w_nextData[7:0];
      endcase
      w_dataBit = w_byte[3'd7 - w_nextBitIdx[2:0]];
      w_sclNext = 1'b1;
      w_sdaNext = 1'b1;
      w_oeNext  = 1'b0;
      unique case (w_nextState)
         S_START: begin
            w_sclNext = (w_nextQuarter != 2'd3);
            w_sdaNext = (w_nextQuarter == 2'd0);
            w_oeNext  = 1'b1;
         end
         S_BIT: begin
            w_sclNext = (w_nextQuarter == 2'd1) || (w_nextQuarter == 2'd2);
            if (w_nextBitIdx == 4'd8) begin
               w_sdaNext = 1'b1;
               w_oeNext  = 1'b0;
            end else begin
               w_sdaNext = w_dataBit;
               w_oeNext  = 1'b1;
            end
         end
         S_STOP: begin
            w_sclNext = (w_nextQuarter != 2'd0);
            w_sdaNext = w_nextQuarter[1];
            w_oeNext  = 1'b1;
         end
         default: begin
            w_sclNext = 1'b1;
            w_sdaNext = 1'b1;
            w_oeNext  = 1'b0;
         end
      endcase
   end

   // State, counters and all outputs; the ACK flag only reaches ack_err at the end of GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_qcnt      <= '0;
         r_quarter   <= 2'd0;
         r_bitIdx    <= 4'd0;
         r_phase     <= 2'd0;
         r_data      <= 16'h0000;
         r_errSticky <= 1'b0;
         busy        <= 1'b0;
         ack_err     <= 1'b0;
         sccb_scl    <= 1'b1;
         sccb_sda_o  <= 1'b1;
         sccb_sda_oe <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_qcnt      <= w_nextQcnt;
         r_quarter   <= w_nextQuarter;
         r_bitIdx    <= w_nextBitIdx;
         r_phase     <= w_nextPhase;
         r_data      <= w_nextData;
         busy        <= (w_nextState != S_IDLE);
         sccb_scl    <= w_sclNext;
         sccb_sda_o  <= w_sdaNext;
         sccb_sda_oe <= w_oeNext;
         if (r_state == S_IDLE && start) begin
            r_errSticky <= 1'b0;
            ack_err     <= 1'b0;
         end else if (w_sampleAck && sccb_sda_i) begin
            r_errSticky <= 1'b1;
         end
         if (r_state == S_GAP && w_stepEnd) begin
            ack_err <= r_errSticky;
         end
      end
   end

endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench for sccb_write_master: a bus monitor decodes frames from the pins
// and each test compares them against bytes and timing derived from the protocol rules.
module tb_sccb_write_master;

   localparam int         CLK_FREQ    = 4_000_000;
   localparam int         SCL_FREQ    = 100_000;
   localparam logic [7:0] DEV_ADDR    = 8'h42;
   localparam int         QDIV        = CLK_FREQ / (4 * SCL_FREQ);
   localparam int         TXN_CYCLES  = 4 * QDIV * (1 + 27 + 1 + 1);
   localparam int         FRAME_RISES = 27 + 1;
   localparam int         SEQ_LEN     = 24;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] cfg_data;
   logic        busy;
   logic        ack_err;
   logic        sccb_scl;
   logic        sccb_sda_o;
   logic        sccb_sda_oe;
   logic        sccb_sda_i;

   int checks = 0;
   int errors = 0;

   logic [3:0]  ackMask = 4'b0000;
   logic [23:0] frameBytesQ[$];
   int          frameRisesQ[$];
   int          busyLenQ[$];
   int          protoErrs = 0;
   int          oeErrs    = 0;

   sccb_write_master #(
      .CLK_FREQ(CLK_FREQ),
      .SCL_FREQ(SCL_FREQ),
      .DEV_ADDR(DEV_ADDR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_data   (cfg_data),
      .busy       (busy),
      .ack_err    (ack_err),
      .sccb_scl   (sccb_scl),
      .sccb_sda_o (sccb_sda_o),
      .sccb_sda_oe(sccb_sda_oe),
      .sccb_sda_i (sccb_sda_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus monitor: START/STOP detection, bit capture on SCL rise, ACK responder, busy length.
   logic        prevScl  = 1'b1;
   logic        prevLine = 1'b1;
   logic        prevOe   = 1'b0;
   logic        prevBusy = 1'b0;
   logic        inFrame  = 1'b0;
   int          bitCnt   = 0;
   int          dcCount  = 0;
   int          busyCnt  = 0;
   logic [23:0] shiftReg = '0;
   logic        line;

   always @(negedge clk) begin
      line = sccb_sda_oe ? sccb_sda_o : 1'b1;
      if (!rst_n) begin
         inFrame    = 1'b0;
         busyCnt    = 0;
         sccb_sda_i = 1'b0;
      end else begin
         if (prevScl && sccb_scl && prevLine && !line) begin
            if (inFrame) protoErrs++;
            inFrame  = 1'b1;
            bitCnt   = 0;
            dcCount  = 0;
            shiftReg = '0;
         end else if (prevScl && sccb_scl && !prevLine && line) begin
            if (!inFrame) protoErrs++;
            else begin
               frameBytesQ.push_back(shiftReg);
               frameRisesQ.push_back(bitCnt);
            end
            inFrame = 1'b0;
         end
         if (!prevScl && sccb_scl && inFrame) begin
            if (bitCnt < 27) begin
               if (bitCnt % 9 == 8) begin
                  if (sccb_sda_oe) oeErrs++;
               end else begin
                  if (!sccb_sda_oe) oeErrs++;
                  shiftReg = {shiftReg[22:0], line};
               end
            end
            bitCnt++;
         end
         if (inFrame && prevOe && !sccb_sda_oe) begin
            sccb_sda_i = (dcCount < 3) ? ackMask[dcCount] : 1'b0;
            dcCount++;
         end else if (!prevOe && sccb_sda_oe) begin
            sccb_sda_i = 1'b0;
         end
         if (busy) busyCnt++;
         else if (prevBusy) begin
            busyLenQ.push_back(busyCnt);
            busyCnt = 0;
         end
      end
      prevScl  = sccb_scl;
      prevLine = line;
      prevOe   = sccb_sda_oe;
      prevBusy = busy && rst_n;
   end

   function automatic logic [23:0] expFrame(input logic [15:0] word);
      return {DEV_ADDR, word};
   endfunction

   task automatic waitIdle(input int maxCycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulseStart(input logic [15:0] word, input logic [3:0] mask);
      @(negedge clk);
      cfg_data = word;
      ackMask  = mask;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic popFrame(output bit got, output logic [23:0] bytes, output int rises);
      got   = (frameBytesQ.size() > 0);
      bytes = '0;
      rises = -1;
      if (got) begin
         bytes = frameBytesQ.pop_front();
         rises = frameRisesQ.pop_front();
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      cfg_data = 16'h0000;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (ack_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack_err: got %b expected 0", ack_err); end
      checks++; if (sccb_scl !== 1'b1) begin errors++; $display("[TB] FAIL reset_scl: got %b expected 1", sccb_scl); end
      checks++; if (sccb_sda_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda_o: got %b expected 1", sccb_sda_o); end
      checks++; if (sccb_sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", sccb_sda_oe); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || sccb_scl !== 1'b1) begin errors++; $display("[TB] FAIL idle_after_reset: busy=%b scl=%b expected 0/1", busy, sccb_scl); end
   endtask

   task automatic test_single_write();
      bit ok, got;
      logic [23:0] bytes;
      int rises, len;
      pulseStart(16'h1204, 4'b0000);
      waitIdle(TXN_CYCLES + 20, ok);
      @(negedge clk);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: busy still %b expected 0", busy); end
      len = (busyLenQ.size() > 0) ? busyLenQ.pop_front() : -1;
      checks++; if (len != TXN_CYCLES) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", len, TXN_CYCLES); end
      popFrame(got, bytes, rises);
      checks++; if (!got || bytes !== 24'h421204) begin errors++; $display("[TB] FAIL single_bytes: got %h (frame=%b) expected 421204", bytes, got); end
      checks++; if (rises != FRAME_RISES) begin errors++; $display("[TB] FAIL single_rises: got %0d expected %0d", rises, FRAME_RISES); end
      checks++; if (ack_err !== 1'b0) begin errors++; $display("[TB] FAIL single_ack_err: got %b expected 0", ack_err); end
   endtask

   task automatic test_held_start();
      bit ok, got;
      logic [23:0] bytes;
      logic [15:0] word;
      int rises, nFrames, nBusy, len;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      word = 16'($urandom);
      cfg_data = word;
      ackMask  = 4'b0000;
      start    = 1'b1;
      repeat (10) @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      cfg_data = ~word;
      waitIdle(TXN_CYCLES + 20, ok);
      repeat (30) @(negedge clk);
      nFrames = frameBytesQ.size();
      nBusy   = busyLenQ.size();
      checks++; if (!ok) begin errors++; $display("[TB] FAIL held_timeout: busy %b expected 0", busy); end
      checks++; if (nFrames != 1 || nBusy != 1) begin errors++; $display("[TB] FAIL held_count: got %0d frames %0d busy periods expected 1/1", nFrames, nBusy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_retrigger: busy %b expected 0", busy); end
      popFrame(got, bytes, rises);
      checks++; if (bytes !== expFrame(word)) begin errors++; $display("[TB] FAIL held_bytes: got %h expected %h", bytes, expFrame(word)); end
      len = (busyLenQ.size() > 0) ? busyLenQ.pop_front() : -1;
      checks++; if (len != TXN_CYCLES) begin errors++; $display("[TB] FAIL held_busy_len: got %0d expected %0d", len, TXN_CYCLES); end
      frameBytesQ.delete(); frameRisesQ.delete(); busyLenQ.delete();
   endtask

   task automatic test_ack_error();
      bit ok, got;
      logic [23:0] bytes;
      logic [15:0] word;
      int rises;
      word = 16'($urandom);
      pulseStart(word, 4'b0010);
      waitIdle(TXN_CYCLES + 20, ok);
      checks++; if (!ok || ack_err !== 1'b1) begin errors++; $display("[TB] FAIL ack_set: got %b (idle=%b) expected 1", ack_err, ok); end
      @(negedge clk);
      popFrame(got, bytes, rises);
      checks++; if (bytes !== expFrame(word) || rises != FRAME_RISES) begin errors++; $display("[TB] FAIL ack_frame: got %h/%0d expected %h/%0d", bytes, rises, expFrame(word), FRAME_RISES); end
      word = 16'($urandom);
      pulseStart(word, 4'b0000);
      checks++; if (ack_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ack_clear: ack_err=%b busy=%b expected 0/1", ack_err, busy); end
      waitIdle(TXN_CYCLES + 20, ok);
      @(negedge clk);
      checks++; if (!ok || ack_err !== 1'b0) begin errors++; $display("[TB] FAIL ack_clean: got %b expected 0", ack_err); end
      popFrame(got, bytes, rises);
      checks++; if (bytes !== expFrame(word)) begin errors++; $display("[TB] FAIL ack_clean_bytes: got %h expected %h", bytes, expFrame(word)); end
      busyLenQ.delete();
   endtask

   task automatic test_reset_mid();
      bit ok, got;
      logic [23:0] bytes;
      logic [15:0] word;
      int rises, len;
      pulseStart(16'($urandom), 4'b0000);
      repeat (498) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || sccb_scl !== 1'b1 || sccb_sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pins: busy=%b scl=%b oe=%b expected 0/1/0", busy, sccb_scl, sccb_sda_oe); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      frameBytesQ.delete(); frameRisesQ.delete(); busyLenQ.delete();
      word = 16'($urandom);
      pulseStart(word, 4'b0000);
      waitIdle(TXN_CYCLES + 20, ok);
      @(negedge clk);
      popFrame(got, bytes, rises);
      checks++; if (!ok || bytes !== expFrame(word) || rises != FRAME_RISES) begin errors++; $display("[TB] FAIL midreset_next: got %h/%0d expected %h/%0d", bytes, rises, expFrame(word), FRAME_RISES); end
      len = (busyLenQ.size() > 0) ? busyLenQ.pop_front() : -1;
      checks++; if (len != TXN_CYCLES) begin errors++; $display("[TB] FAIL midreset_busy_len: got %0d expected %0d", len, TXN_CYCLES); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] table_q[SEQ_LEN];
      logic [3:0]  masks[SEQ_LEN];
      bit ok, got;
      logic [23:0] bytes;
      int rises, len;
      for (int i = 0; i < SEQ_LEN; i++) begin
         table_q[i] = 16'($urandom);
         masks[i]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 7)) : 4'b0000;
      end
      table_q[0]         = 16'h3a04;
      table_q[SEQ_LEN-1] = 16'h1e01;
      for (int i = 0; i < SEQ_LEN; i++) begin
         pulseStart(table_q[i], masks[i]);
         waitIdle(TXN_CYCLES + 20, ok);
         checks++; if (!ok || ack_err !== (masks[i][2:0] != 3'b000)) begin errors++; $display("[TB] FAIL seq_ack[%0d]: got %b (idle=%b) expected %b", i, ack_err, ok, masks[i][2:0] != 3'b000); end
         repeat (2) @(negedge clk);
      end
      checks++; if (frameBytesQ.size() != SEQ_LEN) begin errors++; $display("[TB] FAIL seq_count: got %0d expected %0d", frameBytesQ.size(), SEQ_LEN); end
      for (int i = 0; i < SEQ_LEN; i++) begin
         popFrame(got, bytes, rises);
         len = (busyLenQ.size() > 0) ? busyLenQ.pop_front() : -1;
         checks++; if (bytes !== expFrame(table_q[i]) || rises != FRAME_RISES || len != TXN_CYCLES) begin errors++; $display("[TB] FAIL seq_frame[%0d]: got %h/%0d/%0d expected %h/%0d/%0d", i, bytes, rises, len, expFrame(table_q[i]), FRAME_RISES, TXN_CYCLES); end
      end
   endtask

   task automatic test_protocol();
      checks++; if (protoErrs != 0) begin errors++; $display("[TB] FAIL protocol_sda_while_scl_high: got %0d events expected 0", protoErrs); end
      checks++; if (oeErrs != 0) begin errors++; $display("[TB] FAIL protocol_oe: got %0d bad bits expected 0", oeErrs); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_held_start();
      test_ack_error();
      test_reset_mid();
      test_back_to_back();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
